// File: rtl/mul_div_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// The decoder and hazard unit import the same op constants.
package mul_div_unit_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_CALC = 2'b01,
    MD_FIX  = 2'b10
  } md_state_e;

  function automatic logic md_is_signed(input md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic md_is_div(input md_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/result bundle between EX-stage issue logic (master) and the
// multiply/divide unit (slave).
interface mul_div_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             dbz;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, hi, lo, dbz
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, hi, lo, dbz
  );
endinterface

// File: rtl/mul_div_unit_sign_fix.sv
// Conditional two's-complement negate: magnitude extraction on the way in,
// sign correction on the way out.
module md_sign_fix #(
  parameter int N = 32
) (
  input  logic [N-1:0] i_val,
  input  logic         i_neg,
  output logic [N-1:0] o_res
);
  assign o_res = i_neg ? (~i_val + {{(N-1){1'b0}}, 1'b1}) : i_val;
endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one bit per cycle on magnitudes,
// sign correction in a final FIX cycle, results held in HI/LO.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  mul_div_unit_if.slave  md
);
  localparam int CNT_W = $clog2(WIDTH);

  md_state_e          r_state;
  md_op_e             r_op;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH:0]     r_rem;
  logic [WIDTH-1:0]   r_mag_b;
  logic [WIDTH-1:0]   r_a_orig;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_dbz;

  md_op_e             w_op_in;
  logic               w_in_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH+1:0]   w_shift;
  logic [WIDTH+1:0]   w_diff;
  logic               w_q_bit;
  logic [WIDTH:0]     w_rem_next;
  logic [WIDTH-1:0]   w_quo_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_remd;

  assign w_op_in     = md_op_e'(md.op);
  assign w_in_signed = md_is_signed(w_op_in);
  assign w_a_neg     = w_in_signed & md.a[WIDTH-1];
  assign w_b_neg     = w_in_signed & md.b[WIDTH-1];

  md_sign_fix #(.N(WIDTH)) u_mag_a (.i_val(md.a), .i_neg(w_a_neg), .o_res(w_a_mag));
  md_sign_fix #(.N(WIDTH)) u_mag_b (.i_val(md.b), .i_neg(w_b_neg), .o_res(w_b_mag));

  // Shift-add: multiplier sits in the low half of r_acc and shifts out LSB first.
  assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                      (r_acc[0] ? {1'b0, r_mag_b} : {(WIDTH+1){1'b0}});
  assign w_mul_next = {w_sum, r_acc[WIDTH-1:1]};

  // Restoring divide: dividend shifts out of r_acc's low half, quotient shifts in.
  assign w_shift    = {r_rem, r_acc[WIDTH-1]};
  assign w_diff     = w_shift - {2'b00, r_mag_b};
  assign w_q_bit    = ~w_diff[WIDTH+1];
  assign w_rem_next = w_q_bit ? w_diff[WIDTH:0] : w_shift[WIDTH:0];
  assign w_quo_next = {r_acc[WIDTH-2:0], w_q_bit};

  md_sign_fix #(.N(2*WIDTH)) u_fix_prod (.i_val(r_acc), .i_neg(r_neg_q), .o_res(w_prod));
  md_sign_fix #(.N(WIDTH)) u_fix_quot (.i_val(r_acc[WIDTH-1:0]), .i_neg(r_neg_q), .o_res(w_quot));
  md_sign_fix #(.N(WIDTH)) u_fix_rem (.i_val(r_rem[WIDTH-1:0]), .i_neg(r_neg_r), .o_res(w_remd));

  // Control FSM, datapath registers and registered HI/LO/flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= MD_IDLE;
      r_op     <= MD_MULT;
      r_cnt    <= {CNT_W{1'b0}};
      r_acc    <= {(2*WIDTH){1'b0}};
      r_rem    <= {(WIDTH+1){1'b0}};
      r_mag_b  <= {WIDTH{1'b0}};
      r_a_orig <= {WIDTH{1'b0}};
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= {WIDTH{1'b0}};
      r_lo     <= {WIDTH{1'b0}};
      r_dbz    <= 1'b0;
    end else if (md.flush) begin
      r_state <= MD_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        MD_IDLE: begin
          r_done <= 1'b0;
          if (md.start) begin
            r_op     <= w_op_in;
            r_cnt    <= CNT_W'(WIDTH - 1);
            r_acc    <= {{WIDTH{1'b0}}, w_a_mag};
            r_rem    <= {(WIDTH+1){1'b0}};
            r_mag_b  <= w_b_mag;
            r_a_orig <= md.a;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_busy   <= 1'b1;
            r_state  <= MD_CALC;
          end
        end
        MD_CALC: begin
          if (md_is_div(r_op)) begin
            r_rem             <= w_rem_next;
            r_acc[WIDTH-1:0]  <= w_quo_next;
          end else begin
            r_acc <= w_mul_next;
          end
          if (r_cnt == {CNT_W{1'b0}}) begin
            r_state <= MD_FIX;
          end else begin
            r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        MD_FIX: begin
          if (md_is_div(r_op)) begin
            // Zero divisor reports the original dividend, not its magnitude.
            if (r_mag_b == {WIDTH{1'b0}}) begin
              r_hi  <= r_a_orig;
              r_lo  <= {WIDTH{1'b1}};
              r_dbz <= 1'b1;
            end else begin
              r_hi  <= w_remd;
              r_lo  <= w_quot;
              r_dbz <= 1'b0;
            end
          end else begin
            r_hi  <= w_prod[2*WIDTH-1:WIDTH];
            r_lo  <= w_prod[WIDTH-1:0];
            r_dbz <= 1'b0;
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= MD_IDLE;
        end
        default: begin
          r_state <= MD_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign md.busy = r_busy;
  assign md.done = r_done;
  assign md.hi   = r_hi;
  assign md.lo   = r_lo;
  assign md.dbz  = r_dbz;

endmodule

// File: tb/tb_mul_div_unit.sv
// Table-driven bench for mul_div_unit with a result scoreboard and
// hand-written sequences for ignored start, flush and async reset.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  localparam int W = 32;

  typedef struct {
    md_op_e      op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_err;
  int   edge_n;
  exp_t sb[$];
  vec_t vecs[13];

  mul_div_unit_if #(.WIDTH(W)) md ();

  mul_div_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .md  (md)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic start_op(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    md.start = 1'b1;
    md.op    = op;
    md.a     = a;
    md.b     = b;
    @(posedge clk);
    #1;
    edge_n   = 0;
    md.start = 1'b0;
    md.a     = $urandom;
    md.b     = $urandom;
    md.op    = 2'($urandom);
  endtask

  task automatic push_exp(input logic [31:0] hi, input logic [31:0] lo, input logic dbz);
    exp_t e;
    e.hi  = hi;
    e.lo  = lo;
    e.dbz = dbz;
    sb.push_back(e);
  endtask

  task automatic wait_done(input string name);
    bit   busy_ok;
    exp_t e;
    busy_ok = 1'b1;
    while (md.done !== 1'b1 && edge_n < 100) begin
      if (md.busy !== 1'b1) busy_ok = 1'b0;
      tick();
    end
    if (md.done !== 1'b1) begin
      check({name, " done_timeout"}, 64'(md.done), 64'd1);
    end else begin
      check({name, " latency"}, 64'(edge_n), 64'(W + 1));
      check({name, " busy_in_flight"}, 64'(busy_ok), 64'd1);
      check({name, " busy_at_done"}, 64'(md.busy), 64'd0);
      if (sb.size() == 0) begin
        check({name, " scoreboard_empty"}, 64'd0, 64'd1);
      end else begin
        e = sb.pop_front();
        check({name, " hi"}, 64'(md.hi), 64'(e.hi));
        check({name, " lo"}, 64'(md.lo), 64'(e.lo));
        check({name, " dbz"}, 64'(md.dbz), 64'(e.dbz));
      end
      tick();
      check({name, " done_pulse"}, 64'(md.done), 64'd0);
    end
  endtask

  initial begin
    bit saw_done;
    vecs[0]  = '{MD_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    vecs[1]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[2]  = '{MD_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
    vecs[3]  = '{MD_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
    vecs[4]  = '{MD_MULT,  32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 1'b0};
    vecs[5]  = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[6]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[7]  = '{MD_DIVU,  32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1'b1};
    vecs[8]  = '{MD_DIV,   32'hFFFFFF00, 32'h00000000, 32'hFFFFFF00, 32'hFFFFFFFF, 1'b1};
    vecs[9]  = '{MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[10] = '{MD_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0};
    vecs[11] = '{MD_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};
    vecs[12] = '{MD_DIVU,  32'h00000005, 32'h00000009, 32'h00000005, 32'h00000000, 1'b0};

    n_checks = 0;
    n_err    = 0;
    edge_n   = 0;
    rst      = 1'b1;
    md.start = 1'b0;
    md.flush = 1'b0;
    md.op    = 2'b00;
    md.a     = 32'h0;
    md.b     = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset busy", 64'(md.busy), 64'd0);
    check("reset done", 64'(md.done), 64'd0);
    check("reset hi", 64'(md.hi), 64'd0);
    check("reset lo", 64'(md.lo), 64'd0);
    check("reset dbz", 64'(md.dbz), 64'd0);

    for (int i = 0; i < 13; i++) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b);
      push_exp(vecs[i].hi, vecs[i].lo, vecs[i].dbz);
      wait_done($sformatf("vec%0d", i));
    end

    // Start with new operands at E5 while busy must be ignored.
    start_op(MD_DIVU, 32'd100, 32'd7);
    push_exp(32'h00000002, 32'h0000000E, 1'b0);
    while (edge_n < 4) tick();
    @(negedge clk);
    md.start = 1'b1;
    md.op    = MD_MULT;
    md.a     = 32'd5;
    md.b     = 32'd1;
    tick();
    md.start = 1'b0;
    wait_done("ignored_start");

    // Establish a distinctive prior result, then flush an operation at E10.
    start_op(MD_DIVU, 32'd100, 32'd0);
    push_exp(32'h00000064, 32'hFFFFFFFF, 1'b1);
    wait_done("prior_dbz");
    start_op(MD_DIVU, 32'd100, 32'd7);
    while (edge_n < 9) tick();
    @(negedge clk);
    md.flush = 1'b1;
    tick();
    md.flush = 1'b0;
    check("flush busy", 64'(md.busy), 64'd0);
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (md.done === 1'b1) saw_done = 1'b1;
    end
    check("flush no_done", 64'(saw_done), 64'd0);
    check("flush hi_kept", 64'(md.hi), 64'h64);
    check("flush lo_kept", 64'(md.lo), 64'hFFFFFFFF);
    check("flush dbz_kept", 64'(md.dbz), 64'd1);

    // Flush and start together in IDLE: not started.
    @(negedge clk);
    md.start = 1'b1;
    md.flush = 1'b1;
    md.op    = MD_DIVU;
    md.a     = 32'd100;
    md.b     = 32'd7;
    tick();
    md.start = 1'b0;
    md.flush = 1'b0;
    check("flush_start busy", 64'(md.busy), 64'd0);

    // Asynchronous reset at E10 clears everything at once.
    start_op(MD_DIVU, 32'd100, 32'd7);
    while (edge_n < 9) tick();
    #2;
    rst = 1'b1;
    #1;
    check("async_rst busy", 64'(md.busy), 64'd0);
    check("async_rst done", 64'(md.done), 64'd0);
    check("async_rst hi", 64'(md.hi), 64'd0);
    check("async_rst lo", 64'(md.lo), 64'd0);
    check("async_rst dbz", 64'(md.dbz), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    start_op(MD_DIVU, 32'd100, 32'd7);
    push_exp(32'h00000002, 32'h0000000E, 1'b0);
    wait_done("after_reset");

    check("scoreboard drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Parametrised iterative multiply/divide unit for the 5-stage MIPS pipeline, sitting in EX beside the combinational ALU. It executes MULT/MULTU/DIV/DIVU over multiple cycles with a start/busy/done handshake and holds the results in HI/LO registers. While busy, the hazard unit stalls any dependent instruction. It extends the single-cycle ALU with signed/unsigned multi-cycle operations and a configurable width.

## Interface
- WIDTH, 32, operand width; ≥ 4; HI and LO are each WIDTH bits
- clk  input  1  clock, rising edge
- rst  input  1  reset rst, asynchronous, active-high
- start  input  1  request; sampled only in IDLE
- op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- a  input  WIDTH  multiplicand / dividend (rs)
- b  input  WIDTH  multiplier / divisor (rt)
- flush  input  1  abort current operation (branch/jump squash)
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle pulse: hi/lo just updated
- hi  output  WIDTH  product upper half / remainder
- lo  output  WIDTH  product lower half / quotient
- dbz  output  1  last completed DIV/DIVU had b == 0; held until the next completion

## Operation
- States: IDLE, CALC, FIX. busy = (state != IDLE).
- IDLE, start=1, flush=0: latch op, take magnitudes of a and b for signed ops, record the result sign(s), set iteration counter = WIDTH-1, go to CALC.
- CALC, multiply: radix-2 shift-add on magnitudes into a 2·WIDTH accumulator, one bit per cycle.
- CALC, divide: restoring division, one quotient bit per cycle; remainder register is WIDTH+1 bits.
- CALC lasts exactly WIDTH cycles. Exit to FIX when the counter reaches 0.
- FIX: apply two's-complement sign correction.
  - MULT: negate the 2·WIDTH product if the signs of a and b differed.
  - DIV: quotient is negative if the signs differed; remainder takes the sign of the dividend (truncating division).
  - Load hi/lo and dbz, pulse done, return to IDLE.
- Divide by zero (b == 0): hi = original a, lo = all ones, dbz = 1. Latency is unchanged.
- Signed overflow (DIV of the most negative value by -1): lo = most negative value, hi = 0, dbz = 0.
- start while busy: ignored. No queueing, no error.
- flush in any state: next state IDLE. No done pulse; hi, lo and dbz keep their prior values.
- flush and start in the same IDLE cycle: flush wins and the operation is not started.
- Width rules: all arithmetic is modulo 2·WIDTH. Counter width is $clog2(WIDTH).

## Timing
- Reset values: state IDLE, busy 0, done 0, hi 0, lo 0, dbz 0, all internal registers 0.
- Reset mid-operation: immediate abort to the reset values. hi/lo are cleared.
- Start accepted at edge E0. busy is high after E0.
- CALC spans edges E1..E_WIDTH.
- At E_WIDTH+1: hi/lo/dbz are loaded, done goes to 1, busy goes to 0.
- done is high for exactly the cycle after E_WIDTH+1. Total latency is WIDTH+1 edges.
- A new start may be sampled in the same cycle that done is high, since state is IDLE. hi/lo stay valid until the next FIX.
- a, b and op are sampled only at E0 and may change afterwards.

## Structure
- Shared package/header:
  - op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU)
  - state encodings (MD_IDLE, MD_CALC, MD_FIX)
- The hazard unit and decoder import the same op constants.
- Single module, with one natural sub-module `md_sign_fix` (combinational magnitude/negate helper). It is instantiated for operand preparation and for result correction.

## Test plan
- MULT a=FFFFFFFD (-3), b=00000005 → done at E33; hi=FFFFFFFF, lo=FFFFFFF1; busy high for E1..E32.
- MULTU a=b=FFFFFFFF → hi=FFFFFFFE, lo=00000001.
- DIV a=FFFFFFF9 (-7), b=00000002 → lo=FFFFFFFD, hi=FFFFFFFF.
- DIV a=80000000, b=FFFFFFFF → lo=80000000, hi=0, dbz=0.
- DIVU a=00000064, b=0 → hi=00000064, lo=FFFFFFFF, dbz=1 at E33.
- DIVU 100/7 started, then:
  - start with new operands at E5 → ignored; result lo=0000000E, hi=00000002.
  - flush at E10 → no done; hi/lo keep the prior result.
  - rst asserted at E10 → all outputs 0 immediately.
